// File: rtl/sdram_rd_fifo.sv
// ---------------------------------------------------------------------------
// sdram_rd_fifo
//
// Single-clock synchronous FIFO that sits in the SDRAM clock domain. It
// buffers SDRAM read data and capture header words on their way to the USB
// output path. Reads are standard (not fall-through): the word appears on
// dout in the cycle after the edge that accepts the read.
//
// Ports:
//   sdram_clk      in   sole clock, rising edge
//   sdram_rst_n    in   asynchronous active-low reset
//   srst           in   synchronous active-high clear (loopback flush)
//   din            in   write data [DATA_W]
//   wr_en          in   write request (ignored while full)
//   rd_en          in   read request (ignored while empty)
//   dout           out  registered read data [DATA_W]
//   full           out  FIFO holds 2**ADDR_W words
//   empty          out  FIFO holds no words
//   wr_data_count  out  occupancy [ADDR_W], saturates at all-ones when full
//   rd_data_count  out  same value as wr_data_count
//
// Optional status outputs, present only when SDRAM_RD_FIFO_STATUS_EN is
// defined:
//   overflow       out  one-cycle pulse, a cycle after wr_en hit a full FIFO
//   underflow      out  one-cycle pulse, a cycle after rd_en hit an empty FIFO
//   almost_full    out  registered, occupancy >= 2**ADDR_W - 256
// ---------------------------------------------------------------------------
module sdram_rd_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst_n,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] wr_data_count,
  output logic [ADDR_W-1:0] rd_data_count
`ifdef SDRAM_RD_FIFO_STATUS_EN
  ,
  output logic              overflow,
  output logic              underflow,
  output logic              almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Occupancy needs one extra bit so that "completely full" is representable.
  localparam logic [ADDR_W:0]   OCC_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   OCC_ONE  = 1;
  localparam logic [ADDR_W:0]   OCC_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   occ_reg,    occ_next;
  logic [DATA_W-1:0] dout_reg;

  logic wr_accept;
  logic rd_accept;

  // Flags come straight from the registered occupancy, so they change on the
  // same edge as the counts and never see the request inputs directly.
  assign full  = (occ_reg == OCC_FULL);
  assign empty = (occ_reg == OCC_ZERO);

  // A write into a full FIFO is dropped even if a read frees a slot on the
  // same edge; likewise a read from empty is dropped even alongside a write.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;

    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pointer, occupancy and output data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      dout_reg   <= '0;
    end else if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      // Synchronous RAM read: dout only moves on an accepted read and
      // otherwise holds the last word delivered.
      if (rd_accept) begin
        dout_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign dout = dout_reg;

  // -------------------------------------------------------------------------
  // Storage: simple dual-port RAM, write port only. Contents are not reset.
  // A write presented together with srst is discarded.
  // -------------------------------------------------------------------------
  always_ff @(posedge sdram_clk) begin
    if (wr_accept && !srst) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // -------------------------------------------------------------------------
  // Count outputs: the low ADDR_W bits of occupancy, OR'd with the top bit so
  // a full FIFO reports all-ones instead of wrapping to zero.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_count
      assign wr_data_count[gi] = occ_reg[gi] | occ_reg[ADDR_W];
      assign rd_data_count[gi] = occ_reg[gi] | occ_reg[ADDR_W];
    end
  endgenerate

`ifdef SDRAM_RD_FIFO_STATUS_EN
  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  localparam logic [ADDR_W:0] AF_LEVEL = OCC_FULL - (OCC_ONE << 8);

  logic overflow_reg;
  logic underflow_reg;
  logic almost_full_reg;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      almost_full_reg <= 1'b0;
    end else if (srst) begin
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      almost_full_reg <= 1'b0;
    end else begin
      overflow_reg    <= wr_en & full;
      underflow_reg   <= rd_en & empty;
      // Taken from the next occupancy so the flag lines up with the counts.
      almost_full_reg <= (occ_next >= AF_LEVEL);
    end
  end

  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
  assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_sdram_rd_fifo.sv
// ---------------------------------------------------------------------------
// tb_sdram_rd_fifo
//
// Directed phases plus randomized traffic for sdram_rd_fifo. A queue-based
// reference FIFO predicts dout, flags and counts after every clock edge.
// ---------------------------------------------------------------------------
module tb_sdram_rd_fifo;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          sdram_clk   = 1'b0;
  logic          sdram_rst_n = 1'b0;
  logic          srst        = 1'b0;
  logic [DW-1:0] din         = '0;
  logic          wr_en       = 1'b0;
  logic          rd_en       = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [AW-1:0] wr_data_count;
  logic [AW-1:0] rd_data_count;

  sdram_rd_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .sdram_clk     (sdram_clk),
    .sdram_rst_n   (sdram_rst_n),
    .srst          (srst),
    .din           (din),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .dout          (dout),
    .full          (full),
    .empty         (empty),
    .wr_data_count (wr_data_count),
    .rd_data_count (rd_data_count)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents in order, plus the last word delivered.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    int exp_cnt;
    sz      = model_q.size();
    exp_cnt = (sz == DEPTH) ? DEPTH - 1 : sz;
    chk({tag, ".dout"},  32'(dout), 32'(exp_dout));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"},  32'(full), 32'(sz == DEPTH));
    chk({tag, ".wcnt"},  32'(wr_data_count), 32'(exp_cnt));
    chk({tag, ".rcnt"},  32'(rd_data_count), 32'(exp_cnt));
  endtask

  // One clock: apply the FIFO rules to the model, then compare just after
  // the edge. Inputs are changed by the caller after this returns.
  task automatic step(input string tag);
    bit wr_ok;
    bit rd_ok;
    @(posedge sdram_clk);
    if (srst) begin
      model_q.delete();
      exp_dout = '0;
    end else begin
      wr_ok = wr_en && (model_q.size() < DEPTH);
      rd_ok = rd_en && (model_q.size() > 0);
      if (rd_ok) exp_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(din);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // ---------------- power-on reset ----------------
    #3;
    check_all("por");
    #9 sdram_rst_n = 1'b1;

    // ---------------- async reset mid-operation ----------------
    $display("phase: async reset mid-operation");
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 16'(16'h0A00 + i);
      step("pre_rst_wr");
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) step("pre_rst_rd");
    rd_en = 1'b0;
    wr_en = 1'b1;
    din   = 16'h5555;
    sdram_rst_n = 1'b0;
    #2;
    model_q.delete();
    exp_dout = '0;
    check_all("async_rst");
    #10;
    sdram_rst_n = 1'b1;
    wr_en = 1'b0;

    $display("phase: read while empty after reset");
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) step("empty_rd");
    rd_en = 1'b0;

    // ---------------- fill to full ----------------
    $display("phase: fill 1024 words plus one extra");
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      din = 16'(i);
      step("fill");
    end
    chk("full_after_fill", 32'(full), 32'd1);
    chk("count_after_fill", 32'(wr_data_count), 32'd1023);
    din = 16'hBEEF;
    step("fill_extra");
    wr_en = 1'b0;

    // ---------------- drain ----------------
    $display("phase: drain 1024 words");
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step("drain");
      chk("drain_seq", 32'(dout), 32'(i));
    end
    step("drain_extra");
    chk("dout_hold_3ff", 32'(dout), 32'h03FF);
    rd_en = 1'b0;

    // ---------------- wrap-around streaming ----------------
    $display("phase: 3000-word stream at occupancy 5");
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 16'($urandom);
      step("prime");
    end
    rd_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      din = 16'($urandom);
      step("stream");
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) step("stream_drain");
    rd_en = 1'b0;

    // ---------------- simultaneous read/write on empty ----------------
    $display("phase: write and read together while empty");
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 16'h1234;
    step("empty_wr_rd");
    wr_en = 1'b0;
    step("empty_wr_rd_next");
    chk("dout_1234", 32'(dout), 32'h1234);
    rd_en = 1'b0;

    // ---------------- srst flush ----------------
    $display("phase: srst flush with concurrent write");
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 16'(16'hC000 + i);
      step("pre_srst");
    end
    rd_en = 1'b1;
    step("pre_srst_rd");
    rd_en = 1'b0;
    srst  = 1'b1;
    din   = 16'hDEAD;
    step("srst");
    srst  = 1'b0;
    wr_en = 1'b0;
    step("post_srst");

    // ---------------- randomized traffic ----------------
    $display("phase: randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        wr_en = ($urandom_range(0, 3) != 0);
        rd_en = ($urandom_range(0, 3) == 0);
      end else begin
        wr_en = ($urandom_range(0, 3) == 0);
        rd_en = ($urandom_range(0, 3) != 0);
      end
      srst = ($urandom_range(0, 499) == 0);
      din  = 16'($urandom);
      step("random");
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    srst  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
